// File: rtl/rv_alu_sched.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry response buffer returned via valid/ready.
module rv_alu_sched #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req1_op,
   input  logic [XLEN-1:0]  req0_a,
   input  logic [XLEN-1:0]  req0_b,
   input  logic [XLEN-1:0]  req1_a,
   input  logic [XLEN-1:0]  req1_b,
   output logic [3:0]       alu_op,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             alu_zero,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [XLEN-1:0]  rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t     state;
   state_t     state_next;
   logic       buf_valid;
   logic       buf_id;
   logic       rr;
   logic       can_accept;
   logic       has_grant;
   logic       grant_id;
   logic       drain;
   logic       illegal;
   logic [3:0] sel_op;

   assign buf_valid = (state == FULL);

   // Arbitration: a lone requester wins, contention is resolved by rr.
   always_comb begin
      can_accept = rst_n && (!buf_valid || rsp_ready[buf_id]);
      has_grant  = can_accept && (req_valid != 2'b00);
      grant_id   = rr;
      case (req_valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         default: grant_id = rr;
      endcase
      req_ready = 2'b00;
      if (has_grant) req_ready = grant_id ? 2'b10 : 2'b01;
      drain = buf_valid && rsp_ready[buf_id];
   end

   // Operand mux; illegal op codes are executed as ADD and flagged.
   always_comb begin
      sel_op  = grant_id ? req1_op : req0_op;
      illegal = 1'b1;
      case (sel_op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: illegal = 1'b0;
         default:                                       illegal = 1'b1;
      endcase
      alu_op = OP_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (has_grant) begin
         alu_op = illegal ? OP_ADD : sel_op;
         alu_a  = grant_id ? req1_a : req0_a;
         alu_b  = grant_id ? req1_b : req0_b;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (has_grant) state_next = FULL;
         FULL:    if (has_grant) state_next = FULL;
                  else if (drain) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_id       <= 1'b0;
         rr           <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_err      <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         if (has_grant) begin
            buf_id     <= grant_id;
            rr         <= ~grant_id;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= illegal;
         end
         if ((req_valid == 2'b11) && !(&conflict_cnt))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

   assign rsp_valid = buf_valid ? (buf_id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_rv_alu_sched.sv
// Directed bench for rv_alu_sched: vector table plus back-pressure, reset and
// counter saturation sequences, against a behavioural ALU.
module tb_rv_alu_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err;
   logic [3:0]  conflict_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv_alu_sched #(.XLEN(32), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .conflict_cnt(conflict_cnt)
   );

   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'b1100: alu_result = ~(alu_a | alu_b);
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   typedef struct {
      logic [1:0]  valid;
      logic [3:0]  op0;
      logic [31:0] a0, b0;
      logic [3:0]  op1;
      logic [31:0] a1, b1;
      logic [1:0]  rrdy;
      logic [1:0]  e_req_ready;
      logic [3:0]  e_alu_op;
      logic [1:0]  e_rsp_valid;
      logic [31:0] e_result;
      logic        e_zero, e_err;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v,
                        input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic [1:0] rr_in);
      req_valid = v;
      req0_op = o0; req0_a = a0; req0_b = b0;
      req1_op = o1; req1_a = a1; req1_b = b1;
      rsp_ready = rr_in;
   endtask

   initial begin
      //          valid  op0   a0      b0      op1    a1      b1      rrdy   rdy    aop    rspv   result         z     e     cnt
      vecs[0] = '{2'b01, 4'h2, 32'd5,  32'd7,  4'h0,  32'd0,  32'd0,  2'b11, 2'b01, 4'h2, 2'b01, 32'd12,        1'b0, 1'b0, 4'd0};
      vecs[1] = '{2'b10, 4'h0, 32'd0,  32'd0,  4'hF,  32'd3,  32'd4,  2'b11, 2'b10, 4'h2, 2'b10, 32'd7,         1'b0, 1'b1, 4'd0};
      vecs[2] = '{2'b11, 4'h6, 32'd9,  32'd9,  4'h1,  32'hF0, 32'h0F, 2'b11, 2'b01, 4'h6, 2'b01, 32'd0,         1'b1, 1'b0, 4'd1};
      vecs[3] = '{2'b11, 4'h6, 32'd9,  32'd9,  4'h1,  32'hF0, 32'h0F, 2'b11, 2'b10, 4'h1, 2'b10, 32'hFF,        1'b0, 1'b0, 4'd2};
      vecs[4] = '{2'b11, 4'h6, 32'd9,  32'd9,  4'h1,  32'hF0, 32'h0F, 2'b11, 2'b01, 4'h6, 2'b01, 32'd0,         1'b1, 1'b0, 4'd3};
      vecs[5] = '{2'b11, 4'h6, 32'd9,  32'd9,  4'h1,  32'hF0, 32'h0F, 2'b11, 2'b10, 4'h1, 2'b10, 32'hFF,        1'b0, 1'b0, 4'd4};
      vecs[6] = '{2'b00, 4'h0, 32'd0,  32'd0,  4'h0,  32'd0,  32'd0,  2'b11, 2'b00, 4'h2, 2'b00, 32'd0,         1'b0, 1'b0, 4'd4};
      vecs[7] = '{2'b01, 4'h7, 32'hFFFF_FFFF, 32'd1, 4'h0, 32'd0, 32'd0, 2'b11, 2'b01, 4'h7, 2'b01, 32'd1,   1'b0, 1'b0, 4'd4};
      vecs[8] = '{2'b10, 4'h0, 32'd0,  32'd0,  4'hC,  32'd0,  32'd0,  2'b11, 2'b10, 4'hC, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd4};
      vecs[9] = '{2'b01, 4'h0, 32'hF0, 32'h0F, 4'h0,  32'd0,  32'd0,  2'b11, 2'b01, 4'h0, 2'b01, 32'd0,         1'b1, 1'b0, 4'd4};

      // Reset state with both requesters asserting.
      rst_n = 1'b0;
      drive(2'b11, 4'h2, 32'd1, 32'd1, 4'h2, 32'd2, 32'd2, 2'b11);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_cnt", 64'(conflict_cnt), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         logic [31:0] ea, eb;
         drive(vecs[i].valid, vecs[i].op0, vecs[i].a0, vecs[i].b0,
               vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rrdy);
         ea = (vecs[i].e_req_ready == 2'b01) ? vecs[i].a0 :
              (vecs[i].e_req_ready == 2'b10) ? vecs[i].a1 : 32'd0;
         eb = (vecs[i].e_req_ready == 2'b01) ? vecs[i].b0 :
              (vecs[i].e_req_ready == 2'b10) ? vecs[i].b1 : 32'd0;
         #1;
         chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_req_ready));
         chk($sformatf("v%0d_alu_op", i), 64'(alu_op), 64'(vecs[i].e_alu_op));
         chk($sformatf("v%0d_alu_a", i), 64'(alu_a), 64'(ea));
         chk($sformatf("v%0d_alu_b", i), 64'(alu_b), 64'(eb));
         tick();
         chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].e_rsp_valid));
         chk($sformatf("v%0d_cnt", i), 64'(conflict_cnt), 64'(vecs[i].e_cnt));
         if (vecs[i].e_rsp_valid != 2'b00) begin
            chk($sformatf("v%0d_result", i), 64'(rsp_result), 64'(vecs[i].e_result));
            chk($sformatf("v%0d_zero", i), 64'(rsp_zero), 64'(vecs[i].e_zero));
            chk($sformatf("v%0d_err", i), 64'(rsp_err), 64'(vecs[i].e_err));
         end
      end

      // Back-pressure: port 1 owns the buffer and stalls; rr must keep port 0's turn.
      drive(2'b10, 4'h0, 32'd0, 32'd0, 4'h2, 32'd1, 32'd2, 2'b11);
      #1;
      chk("bp_fill_req_ready", 64'(req_ready), 64'b10);
      tick();
      chk("bp_fill_rsp_valid", 64'(rsp_valid), 64'b10);
      chk("bp_fill_result", 64'(rsp_result), 64'd3);
      drive(2'b11, 4'h2, 32'd10, 32'd20, 4'h2, 32'd1, 32'd2, 2'b01);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_stall%0d_req_ready", k), 64'(req_ready), 64'd0);
         chk($sformatf("bp_stall%0d_alu_a", k), 64'(alu_a), 64'd0);
         tick();
         chk($sformatf("bp_stall%0d_rsp_valid", k), 64'(rsp_valid), 64'b10);
         chk($sformatf("bp_stall%0d_result", k), 64'(rsp_result), 64'd3);
      end
      rsp_ready = 2'b10;
      #1;
      chk("bp_release_req_ready", 64'(req_ready), 64'b01);
      chk("bp_release_alu_a", 64'(alu_a), 64'd10);
      tick();
      chk("bp_release_rsp_valid", 64'(rsp_valid), 64'b01);
      chk("bp_release_result", 64'(rsp_result), 64'd30);
      chk("bp_release_cnt", 64'(conflict_cnt), 64'd8);

      // Reset while port 1 holds an undelivered response.
      drive(2'b10, 4'h0, 32'd0, 32'd0, 4'h0, 32'hF0F0, 32'hFF00, 2'b01);
      #1;
      chk("rst_fill_req_ready", 64'(req_ready), 64'b10);
      tick();
      chk("rst_fill_rsp_valid", 64'(rsp_valid), 64'b10);
      chk("rst_fill_result", 64'(rsp_result), 64'hF000);
      drive(2'b01, 4'h2, 32'd1, 32'd1, 4'h0, 32'd0, 32'd0, 2'b00);
      #1;
      chk("rst_hold_req_ready", 64'(req_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_async_cnt", 64'(conflict_cnt), 64'd0);
      chk("rst_async_rr", 64'(dut.rr), 64'd0);
      chk("rst_async_req_ready", 64'(req_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      drive(2'b10, 4'h0, 32'd0, 32'd0, 4'h6, 32'd10, 32'd3, 2'b11);
      #1;
      chk("rst_after_req_ready", 64'(req_ready), 64'b10);
      tick();
      chk("rst_after_rsp_valid", 64'(rsp_valid), 64'b10);
      chk("rst_after_result", 64'(rsp_result), 64'd7);
      chk("rst_after_err", 64'(rsp_err), 64'd0);

      // Conflict counter saturation at 4 bits.
      drive(2'b11, 4'h2, 32'd1, 32'd1, 4'h2, 32'd2, 32'd2, 2'b11);
      tick();
      chk("sat_cnt_1", 64'(conflict_cnt), 64'd1);
      repeat (14) tick();
      chk("sat_cnt_15", 64'(conflict_cnt), 64'd15);
      repeat (5) tick();
      chk("sat_cnt_hold", 64'(conflict_cnt), 64'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv_alu_sched.md
# rv_alu_sched

Round-robin scheduler that shares the single core ALU between two requesters: port 0 (pipeline EX stage) and port 1 (auxiliary address/compare unit). It arbitrates valid/ready requests, drives the ALU's op code and operands from the winner, and captures the result into a one-entry response buffer. The buffer returns the result to the winning port through a valid/ready handshake. The ALU stays purely combinational; this block owns all sequencing around it.

## Interface
Parameters:
- XLEN, 32, operand/result width
- CNT_W, 16, width of the conflict counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, bit i = port i
- req_ready  out  2  request accepted this cycle, bit i = port i
- req0_op, req1_op  in  4  ALU op code per port
- req0_a, req0_b, req1_a, req1_b  in  XLEN  operands per port
- alu_op  out  4  op code to ALU (combinational)
- alu_a, alu_b  out  XLEN  operands to ALU (combinational)
- alu_result  in  XLEN  ALU result (combinational return)
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  2  response valid, one-hot, bit i = port i
- rsp_ready  in  2  response consumed, bit i = port i
- rsp_result  out  XLEN  buffered result
- rsp_zero  out  1  buffered zero flag
- rsp_err  out  1  request carried an illegal op code
- conflict_cnt  out  CNT_W  saturating count of cycles with both req_valid bits set

## Operation
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. Any other code is sent to the ALU as 0010. The buffered rsp_err is set to 1 for that response.
- The response buffer holds: buf_valid, buf_id (0/1), result, zero, err.
- can_accept = rst_n && (!buf_valid || rsp_ready[buf_id]).
- Grant:
  - Only one port valid: that port wins.
  - Both ports valid: the port indicated by pointer rr wins.
  - No request valid, or can_accept low: no grant.
- req_ready[i] = can_accept && grant == i. At most one bit is set.
- Accept = req_valid[i] && req_ready[i]. On accept:
  - buffer loads {1, i, alu_result, alu_zero, illegal}.
  - rr <= ~i.
- rr changes only on accept. A requester that is refused because can_accept is low keeps its turn.
- Drain without accept: rsp_ready[buf_id] high, no accept that cycle → buf_valid <= 0.
- Drain and accept in the same cycle: the buffer is overwritten with the new entry (full throughput).
- rsp_valid = buf_valid ? (1 << buf_id) : 0. rsp_result, rsp_zero and rsp_err are valid only while rsp_valid is nonzero.
- No grant: alu_op = 0010, alu_a = alu_b = 0.
- Requester rules:
  - Keep valid, op and operands stable until accepted. The block does not check this.
  - req_valid must not depend on req_ready.
- conflict_cnt increments on every cycle with req_valid == 2'b11, saturating at all-ones, whether or not a grant occurs.
- State machine:
  - EMPTY (buf_valid = 0): accept → FULL.
  - FULL: drain without accept → EMPTY; drain with accept → FULL; no drain → FULL, and req_ready = 0.

## Timing
- Reset (rst_n low, asynchronous):
  - Cleared: buf_valid, buf_id, rr, rsp_result, rsp_zero, rsp_err, conflict_cnt = 0.
  - rsp_valid = 0 and req_ready = 0 while rst_n is low.
- Reset asserted mid-transaction discards the buffered response. No partial response survives reset.
- Reset deassertion is synchronized externally. The first accept can occur on the first rising edge after rst_n goes high.
- Request path: req → alu_* → alu_result is combinational in the accept cycle. The ALU combinational delay must close within one cycle.
- Latency: accept at edge N → rsp_valid high after edge N, visible in cycle N+1.
- Throughput: one response per cycle while the consumer holds rsp_ready high.
- Back-pressure: rsp_ready low with buf_valid high → req_ready = 2'b00 until drained.
- rsp_ready on a port that does not own the buffer is ignored.

## Test plan
- Single request: port 0 sends op 0010, a = 5, b = 7 with rsp_ready[0] = 1 → req_ready[0] same cycle; next cycle rsp_valid = 01, rsp_result = 12, rsp_zero = 0, rsp_err = 0.
- Contention alternation: both ports valid continuously, port 0 SUB 9−9, port 1 OR 0xF0|0x0F, both rsp_ready high → grants 0,1,0,1…; port 0 responses show result 0, zero = 1; port 1 responses show 0xFF; conflict_cnt increments every cycle.
- Back-pressure: buffer full for port 1 with rsp_ready[1] = 0 for 3 cycles while port 0 is valid → req_ready = 00 for those 3 cycles, rsp_result stable; rr still selects port 0 once rsp_ready[1] rises, and port 0 is accepted that same cycle.
- Illegal op: port 1 sends op 1111, a = 3, b = 4 → alu_op = 0010; response result = 7, rsp_err = 1.
- Reset mid-operation: rst_n pulled low while rsp_valid = 10 → rsp_valid, conflict_cnt and rr read 0 immediately (without waiting for a clock edge); after release, a port 1 request alone is granted and returns a correct result one cycle later.
- Saturation: with CNT_W = 4, hold both ports valid for 20 cycles → conflict_cnt stops at 15.
